// File: rtl/snand_clk_pkg.sv
// Shared types and constants for the SNAND clocking blocks.
// Contents:
//   pll_rst_state_t       - lock supervisor FSM encoding (2 bits)
//   DEF_*_CYCLES          - default cycle counts for the reset sequencer
//   LOSS_CNT_W            - width of the saturating lock-loss counter
//   max3()                - elaboration helper used to size the cycle counter
package snand_clk_pkg;

   typedef enum logic [1:0] {
      PLL_RST   = 2'd0,
      WAIT_LOCK = 2'd1,
      STABLE    = 2'd2,
      RUN       = 2'd3
   } pll_rst_state_t;

   localparam int DEF_PLL_RST_CYCLES      = 16;
   localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
   localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;  // 1 ms at 50 MHz

   localparam int LOSS_CNT_W = 8;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/snand_pll_reset_ctrl_if.sv
// Signal bundle between the PLL lock supervisor and its surroundings.
// master (the supervisor):
//   in  locked        - raw PLL lock, asynchronous to refclk
//   in  relock_req    - single-cycle pulse forcing a PLL re-reset
//   out pll_rst       - PLL reset
//   out sys_rst       - reset for PLL-clocked logic
//   out ready         - high only while running
//   out timeout_err   - sticky lock-timeout flag
//   out lock_loss_cnt - saturating count of lock losses while running
//   out state         - current FSM state, for observation
// slave: the mirror image.
// Handshake: there is no valid/ready transfer here; relock_req is a level
// sampled on every refclk edge, and every output is a registered level.
interface snand_pll_reset_ctrl_if;
   import snand_clk_pkg::*;

   logic                  locked;
   logic                  relock_req;
   logic                  pll_rst;
   logic                  sys_rst;
   logic                  ready;
   logic                  timeout_err;
   logic [LOSS_CNT_W-1:0] lock_loss_cnt;
   pll_rst_state_t        state;

   modport master (
      input  locked, relock_req,
      output pll_rst, sys_rst, ready, timeout_err, lock_loss_cnt, state
   );

   modport slave (
      output locked, relock_req,
      input  pll_rst, sys_rst, ready, timeout_err, lock_loss_cnt, state
   );

endinterface

// File: rtl/snand_sync2.sv
// Generic two-flop synchronizer with asynchronous clear.
// Ports:
//   clk - destination clock
//   clr - asynchronous active-high clear (both flops to 0)
//   d   - asynchronous input
//   q   - synchronized output, two clk edges of latency
module snand_sync2 #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/snand_pll_reset_ctrl.sv
// PLL lock supervisor and system reset sequencer on the 50 MHz refclk domain.
// Holds the PLL in reset, waits for lock, requires lock to stay stable before
// releasing sys_rst, and re-arms the PLL on lock timeout or relock_req.
// Ports:
//   refclk - sole clock
//   rst    - asynchronous active-high reset
//   bus    - snand_pll_reset_ctrl_if.master (lock input, relock request,
//            reset outputs, status flags, lock-loss counter, FSM state)
module snand_pll_reset_ctrl
   import snand_clk_pkg::*;
#(
   parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
   parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
   parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
   parameter int CNT_W               = 16
) (
   input  logic                    refclk,
   input  logic                    rst,
   snand_pll_reset_ctrl_if.master  bus
);

   if (CNT_W < $clog2(max3(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES)))
   begin : g_cnt_w_check
      $error("snand_pll_reset_ctrl: CNT_W too small for the cycle-count parameters");
   end

   localparam logic [CNT_W-1:0] PLL_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
   localparam logic [LOSS_CNT_W-1:0] LOSS_ONE = LOSS_CNT_W'(1);

   logic                  locked_s;
   pll_rst_state_t        state_q;
   logic [CNT_W-1:0]      cnt_q;
   logic                  pll_rst_q;
   logic                  sys_rst_q;
   logic                  ready_q;
   logic                  timeout_err_q;
   logic [LOSS_CNT_W-1:0] loss_cnt_q;

   snand_sync2 #(.W(1)) u_lock_sync (
      .clk (refclk),
      .clr (rst),
      .d   (bus.locked),
      .q   (locked_s)
   );

   // Outputs are loaded alongside the state so each is a clean flop.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state_q       <= PLL_RST;
         cnt_q         <= '0;
         pll_rst_q     <= 1'b1;
         sys_rst_q     <= 1'b1;
         ready_q       <= 1'b0;
         timeout_err_q <= 1'b0;
         loss_cnt_q    <= '0;
      end else if (bus.relock_req) begin
         // Overrides any pending timeout, so timeout_err is not set here.
         state_q   <= PLL_RST;
         cnt_q     <= '0;
         pll_rst_q <= 1'b1;
         sys_rst_q <= 1'b1;
         ready_q   <= 1'b0;
      end else begin
         case (state_q)
            PLL_RST: begin
               if (cnt_q == PLL_LAST) begin
                  state_q   <= WAIT_LOCK;
                  cnt_q     <= '0;
                  pll_rst_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            WAIT_LOCK: begin
               if (locked_s) begin
                  state_q <= STABLE;
                  cnt_q   <= '0;
               end else if (cnt_q == TIMEOUT_LAST) begin
                  state_q       <= PLL_RST;
                  cnt_q         <= '0;
                  pll_rst_q     <= 1'b1;
                  timeout_err_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            STABLE: begin
               // A drop here is a glitch during qualification, not a loss.
               if (!locked_s) begin
                  state_q <= WAIT_LOCK;
                  cnt_q   <= '0;
               end else if (cnt_q == STABLE_LAST) begin
                  state_q   <= RUN;
                  cnt_q     <= '0;
                  sys_rst_q <= 1'b0;
                  ready_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            RUN: begin
               // Lock loss goes back to waiting without re-resetting the PLL.
               if (!locked_s) begin
                  state_q   <= WAIT_LOCK;
                  cnt_q     <= '0;
                  sys_rst_q <= 1'b1;
                  ready_q   <= 1'b0;
                  if (loss_cnt_q != '1) begin
                     loss_cnt_q <= loss_cnt_q + LOSS_ONE;
                  end
               end
            end
            default: begin
               state_q   <= PLL_RST;
               cnt_q     <= '0;
               pll_rst_q <= 1'b1;
               sys_rst_q <= 1'b1;
               ready_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pll_rst       = pll_rst_q;
   assign bus.sys_rst       = sys_rst_q;
   assign bus.ready         = ready_q;
   assign bus.timeout_err   = timeout_err_q;
   assign bus.lock_loss_cnt = loss_cnt_q;
   assign bus.state         = state_q;

endmodule

// File: tb/tb_snand_pll_reset_ctrl.sv
// Directed bench for snand_pll_reset_ctrl with PLL_RST_CYCLES=4,
// LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=20. Inputs change and outputs
// are sampled on the falling edge of refclk.
module tb_snand_pll_reset_ctrl;
   import snand_clk_pkg::*;

   logic refclk;
   logic rst;
   int   errors;
   int   checks;

   snand_pll_reset_ctrl_if bus();

   snand_pll_reset_ctrl #(
      .PLL_RST_CYCLES      (4),
      .LOCK_STABLE_CYCLES  (8),
      .LOCK_TIMEOUT_CYCLES (20),
      .CNT_W               (16)
   ) dut (
      .refclk (refclk),
      .rst    (rst),
      .bus    (bus.master)
   );

   // ---------------- clock / reset ----------------
   initial begin
      refclk = 1'b0;
      forever #10 refclk = ~refclk;
   end

   task automatic step(input int n);
      repeat (n) @(negedge refclk);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      bus.locked = 1'b0;
      bus.relock_req = 1'b0;
      step(2);
      if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL rst_pll_rst got=%b exp=1", bus.pll_rst); end checks++;
      if (bus.sys_rst !== 1'b1) begin errors++; $display("FAIL rst_sys_rst got=%b exp=1", bus.sys_rst); end checks++;
      if (bus.ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", bus.ready); end checks++;
      if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout_err got=%b exp=0", bus.timeout_err); end checks++;
      if (bus.lock_loss_cnt !== 8'd0) begin errors++; $display("FAIL rst_loss_cnt got=%0d exp=0", bus.lock_loss_cnt); end checks++;
      if (bus.state !== PLL_RST) begin errors++; $display("FAIL rst_state got=%0d exp=%0d", bus.state, PLL_RST); end checks++;
   endtask

   task automatic test_power_up();
      logic e;
      rst = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         step(1);
         e = (i < 4);
         if (bus.pll_rst !== e) begin errors++; $display("FAIL pu_pll_rst edge=%0d got=%b exp=%b", i, bus.pll_rst, e); end checks++;
      end
      if (bus.state !== WAIT_LOCK) begin errors++; $display("FAIL pu_wait_state got=%0d exp=%0d", bus.state, WAIT_LOCK); end checks++;
      step(6);
      bus.locked = 1'b1;
      step(2);
      if (bus.state !== WAIT_LOCK) begin errors++; $display("FAIL pu_k1_state got=%0d exp=%0d", bus.state, WAIT_LOCK); end checks++;
      step(1);
      if (bus.state !== STABLE) begin errors++; $display("FAIL pu_k2_state got=%0d exp=%0d", bus.state, STABLE); end checks++;
      step(7);
      if (bus.sys_rst !== 1'b1) begin errors++; $display("FAIL pu_k9_sys_rst got=%b exp=1", bus.sys_rst); end checks++;
      if (bus.ready !== 1'b0) begin errors++; $display("FAIL pu_k9_ready got=%b exp=0", bus.ready); end checks++;
      step(1);
      if (bus.sys_rst !== 1'b0) begin errors++; $display("FAIL pu_k10_sys_rst got=%b exp=0", bus.sys_rst); end checks++;
      if (bus.ready !== 1'b1) begin errors++; $display("FAIL pu_k10_ready got=%b exp=1", bus.ready); end checks++;
      if (bus.state !== RUN) begin errors++; $display("FAIL pu_k10_state got=%0d exp=%0d", bus.state, RUN); end checks++;
   endtask

   // relock_req while running, then a 3-cycle lock glitch during STABLE.
   task automatic test_relock_and_glitch();
      logic e;
      bus.relock_req = 1'b1;
      step(1);
      bus.relock_req = 1'b0;
      if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL rl_pll_rst got=%b exp=1", bus.pll_rst); end checks++;
      if (bus.sys_rst !== 1'b1) begin errors++; $display("FAIL rl_sys_rst got=%b exp=1", bus.sys_rst); end checks++;
      if (bus.ready !== 1'b0) begin errors++; $display("FAIL rl_ready got=%b exp=0", bus.ready); end checks++;
      for (int i = 1; i <= 4; i++) begin
         step(1);
         e = (i < 4);
         if (bus.pll_rst !== e) begin errors++; $display("FAIL rl_hold edge=%0d got=%b exp=%b", i, bus.pll_rst, e); end checks++;
      end
      step(1);
      if (bus.state !== STABLE) begin errors++; $display("FAIL gl_enter_state got=%0d exp=%0d", bus.state, STABLE); end checks++;
      step(4);
      bus.locked = 1'b0;
      step(3);
      if (bus.state !== WAIT_LOCK) begin errors++; $display("FAIL gl_back_state got=%0d exp=%0d", bus.state, WAIT_LOCK); end checks++;
      if (bus.lock_loss_cnt !== 8'd0) begin errors++; $display("FAIL gl_loss_cnt got=%0d exp=0", bus.lock_loss_cnt); end checks++;
      bus.locked = 1'b1;
      step(10);
      if (bus.sys_rst !== 1'b1) begin errors++; $display("FAIL gl_k9_sys_rst got=%b exp=1", bus.sys_rst); end checks++;
      step(1);
      if (bus.sys_rst !== 1'b0) begin errors++; $display("FAIL gl_k10_sys_rst got=%b exp=0", bus.sys_rst); end checks++;
      if (bus.lock_loss_cnt !== 8'd0) begin errors++; $display("FAIL gl_k10_loss_cnt got=%0d exp=0", bus.lock_loss_cnt); end checks++;
   endtask

   task automatic test_lock_loss();
      logic [7:0] exp_cnt;
      bus.locked = 1'b0;
      step(2);
      if (bus.ready !== 1'b1) begin errors++; $display("FAIL ll_m1_ready got=%b exp=1", bus.ready); end checks++;
      bus.locked = 1'b1;
      step(1);
      if (bus.sys_rst !== 1'b1) begin errors++; $display("FAIL ll_m2_sys_rst got=%b exp=1", bus.sys_rst); end checks++;
      if (bus.ready !== 1'b0) begin errors++; $display("FAIL ll_m2_ready got=%b exp=0", bus.ready); end checks++;
      if (bus.lock_loss_cnt !== 8'd1) begin errors++; $display("FAIL ll_m2_loss_cnt got=%0d exp=1", bus.lock_loss_cnt); end checks++;
      if (bus.pll_rst !== 1'b0) begin errors++; $display("FAIL ll_m2_pll_rst got=%b exp=0", bus.pll_rst); end checks++;
      if (bus.state !== WAIT_LOCK) begin errors++; $display("FAIL ll_m2_state got=%0d exp=%0d", bus.state, WAIT_LOCK); end checks++;
      step(10);
      if (bus.ready !== 1'b1) begin errors++; $display("FAIL ll_relock_ready got=%b exp=1", bus.ready); end checks++;
      for (int i = 2; i <= 300; i++) begin
         exp_cnt = (i > 255) ? 8'd255 : 8'(i);
         bus.locked = 1'b0;
         step(2);
         bus.locked = 1'b1;
         step(1);
         if (bus.lock_loss_cnt !== exp_cnt) begin errors++; $display("FAIL ll_loop_cnt i=%0d got=%0d exp=%0d", i, bus.lock_loss_cnt, exp_cnt); end checks++;
         if (bus.pll_rst !== 1'b0 || bus.ready !== 1'b0) begin errors++; $display("FAIL ll_loop_outs i=%0d got pll_rst=%b ready=%b exp 0/0", i, bus.pll_rst, bus.ready); end checks++;
         step(10);
         if (bus.ready !== 1'b1) begin errors++; $display("FAIL ll_loop_ready i=%0d got=%b exp=1", i, bus.ready); end checks++;
      end
      if (bus.lock_loss_cnt !== 8'd255) begin errors++; $display("FAIL ll_saturated got=%0d exp=255", bus.lock_loss_cnt); end checks++;
   endtask

   task automatic test_rst_mid_stable();
      bus.relock_req = 1'b1;
      step(1);
      bus.relock_req = 1'b0;
      step(5);
      if (bus.state !== STABLE) begin errors++; $display("FAIL rm_pre_state got=%0d exp=%0d", bus.state, STABLE); end checks++;
      step(2);
      #3 rst = 1'b1;
      #1;
      if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL rm_pll_rst got=%b exp=1", bus.pll_rst); end checks++;
      if (bus.sys_rst !== 1'b1) begin errors++; $display("FAIL rm_sys_rst got=%b exp=1", bus.sys_rst); end checks++;
      if (bus.ready !== 1'b0) begin errors++; $display("FAIL rm_ready got=%b exp=0", bus.ready); end checks++;
      if (bus.lock_loss_cnt !== 8'd0) begin errors++; $display("FAIL rm_loss_cnt got=%0d exp=0", bus.lock_loss_cnt); end checks++;
      if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL rm_timeout_err got=%b exp=0", bus.timeout_err); end checks++;
      if (bus.state !== PLL_RST) begin errors++; $display("FAIL rm_state got=%0d exp=%0d", bus.state, PLL_RST); end checks++;
      bus.locked = 1'b0;
      step(1);
      rst = 1'b0;
   endtask

   // relock_req on the edge that would time out, then plain periodic timeouts.
   task automatic test_timeout();
      logic e;
      for (int i = 1; i <= 4; i++) begin
         step(1);
         e = (i < 4);
         if (bus.pll_rst !== e) begin errors++; $display("FAIL to_restart edge=%0d got=%b exp=%b", i, bus.pll_rst, e); end checks++;
      end
      step(19);
      if (bus.state !== WAIT_LOCK) begin errors++; $display("FAIL to_pre_state got=%0d exp=%0d", bus.state, WAIT_LOCK); end checks++;
      bus.relock_req = 1'b1;
      step(1);
      bus.relock_req = 1'b0;
      if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL to_simul_pll_rst got=%b exp=1", bus.pll_rst); end checks++;
      if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL to_simul_timeout_err got=%b exp=0", bus.timeout_err); end checks++;
      for (int i = 1; i <= 4; i++) begin
         step(1);
         e = (i < 4);
         if (bus.pll_rst !== e) begin errors++; $display("FAIL to_simul_hold edge=%0d got=%b exp=%b", i, bus.pll_rst, e); end checks++;
      end
      step(19);
      if (bus.timeout_err !== 1'b0 || bus.pll_rst !== 1'b0) begin errors++; $display("FAIL to_c19 got te=%b pll_rst=%b exp 0/0", bus.timeout_err, bus.pll_rst); end checks++;
      step(1);
      if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL to_c20_timeout_err got=%b exp=1", bus.timeout_err); end checks++;
      if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL to_c20_pll_rst got=%b exp=1", bus.pll_rst); end checks++;
      for (int i = 1; i <= 4; i++) begin
         step(1);
         e = (i < 4);
         if (bus.pll_rst !== e) begin errors++; $display("FAIL to_hold edge=%0d got=%b exp=%b", i, bus.pll_rst, e); end checks++;
      end
      step(19);
      if (bus.pll_rst !== 1'b0) begin errors++; $display("FAIL to_p2_c19_pll_rst got=%b exp=0", bus.pll_rst); end checks++;
      step(1);
      if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL to_p2_c20_pll_rst got=%b exp=1", bus.pll_rst); end checks++;
      bus.locked = 1'b1;
      step(13);
      if (bus.ready !== 1'b1) begin errors++; $display("FAIL to_lock_ready got=%b exp=1", bus.ready); end checks++;
      if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky got=%b exp=1", bus.timeout_err); end checks++;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_power_up();
      test_relock_and_glitch();
      test_lock_loss();
      test_rst_mid_stable();
      test_timeout();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/snand_pll_reset_ctrl.md
# snand_pll_reset_ctrl

Lock supervisor and reset sequencer that sits directly downstream of the SNAND PLL wrapper on the 50 MHz reference domain. It holds the PLL in reset for a fixed interval, then waits for `locked`. It releases the system reset only after lock has been stable for a programmed number of cycles. It also detects lock loss, re-arms the PLL on lock timeout or on software request, and keeps health counters for the SPI spike-driver status registers.

## Interface
Parameters:
- `PLL_RST_CYCLES`, default 16: cycles `pll_rst` is held after entering PLL_RST.
- `LOCK_STABLE_CYCLES`, default 1024: consecutive locked cycles required before releasing `sys_rst`.
- `LOCK_TIMEOUT_CYCLES`, default 50000: maximum cycles in WAIT_LOCK (1 ms at 50 MHz) before the PLL is re-reset.
- `CNT_W`, default 16: shared cycle-counter width. Must be ≥ clog2 of the largest count parameter; checked at elaboration.

Ports:
- `refclk`, in, 1: sole clock, 50 MHz reference.
- `rst`, in, 1: asynchronous, active-high reset.
- `locked`, in, 1: PLL lock, asynchronous to `refclk`.
- `relock_req`, in, 1: single-cycle pulse that forces a PLL re-reset.
- `pll_rst`, out, 1: drives the PLL `rst` input.
- `sys_rst`, out, 1: active-high reset for the PLL-clocked logic. Assertion and deassertion are synchronous to `refclk`.
- `ready`, out, 1: high only in RUN.
- `timeout_err`, out, 1: sticky flag set on lock timeout; cleared only by `rst`.
- `lock_loss_cnt`, out, 8: count of lock losses while in RUN; saturates at 255.

## Operation
- `locked` is passed through a 2-flop synchronizer; its output is `locked_s`.
- FSM states are PLL_RST, WAIT_LOCK, STABLE and RUN. One counter `cnt` is shared by all states and cleared on every state transition.
- PLL_RST:
  - `pll_rst`=1, `sys_rst`=1.
  - `cnt` increments each cycle.
  - At `cnt`==PLL_RST_CYCLES-1, go to WAIT_LOCK.
- WAIT_LOCK:
  - `pll_rst`=0, `sys_rst`=1.
  - If `locked_s`=1, go to STABLE.
  - Otherwise `cnt` increments. At `cnt`==LOCK_TIMEOUT_CYCLES-1, go to PLL_RST and set `timeout_err`.
- STABLE:
  - `sys_rst`=1.
  - If `locked_s`=0, go to WAIT_LOCK. This is not a counted loss.
  - Otherwise `cnt` increments. At `cnt`==LOCK_STABLE_CYCLES-1, go to RUN.
- RUN:
  - `sys_rst`=0, `ready`=1.
  - If `locked_s`=0, go to WAIT_LOCK and increment `lock_loss_cnt` (saturating). The PLL is not reset.
- `relock_req`=1 in any state moves the FSM to PLL_RST with `cnt` cleared. This also applies in PLL_RST, where it restarts the hold interval.
- Priority: `rst` > `relock_req` > timeout/lock transitions.
- Every output is a dedicated flop, loaded on the same edge as the state change, so there are no combinational glitches.

## Timing
- Reset values: state=PLL_RST, `cnt`=0, `pll_rst`=1, `sys_rst`=1, `ready`=0, `timeout_err`=0, `lock_loss_cnt`=0, synchronizer flops=0.
- After `rst` is released, `pll_rst` stays high for exactly PLL_RST_CYCLES rising edges.
- Lock-rise latency: if `locked` rises before edge k, the FSM enters STABLE at edge k+2, and `sys_rst` falls with `ready` rising at edge k+2+LOCK_STABLE_CYCLES.
- Lock-loss latency: if `locked` falls before edge m, `sys_rst` rises and `ready` falls at edge m+2.
- `relock_req` sampled at edge n: `pll_rst`=1, `sys_rst`=1 and `ready`=0 at edge n.
- A `rst` asserted mid-sequence forces all outputs to their reset values immediately, without waiting for a clock.

## Structure
- Package `snand_clk_pkg` holds:
  - the `pll_rst_state_t` enum (2 bits: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3);
  - default constants for the three cycle-count parameters;
  - the lock-loss counter width (8).
- Sub-module `snand_sync2` is the generic 2-flop synchronizer with asynchronous clear, reused by the other CDC inputs.

## Test plan
Use PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=20 for all scenarios.
- Power-up: release `rst`, raise `locked` 10 cycles later → `pll_rst` is high for exactly 4 edges, then `sys_rst` falls and `ready` rises 2+8 edges after `locked` rises.
- Lock glitch in STABLE: drop `locked` for 3 cycles after 5 stable cycles → FSM returns to WAIT_LOCK, `lock_loss_cnt` stays 0, and `sys_rst` releases 10 edges after `locked` rises again.
- Lock loss in RUN: drop `locked` → `sys_rst`=1 and `ready`=0 two edges later, `lock_loss_cnt`=1, `pll_rst` stays 0. Repeat 300 times → `lock_loss_cnt`=255.
- Timeout: keep `locked`=0 → after 20 WAIT_LOCK cycles, `timeout_err`=1 and `pll_rst`=1 for 4 cycles, repeating periodically. `timeout_err` stays 1 after lock is achieved.
- `relock_req` in RUN, and `relock_req` on the same edge as a timeout → PLL_RST entered and `pll_rst` held for 4 edges from the request; `timeout_err` is not set in the simultaneous case.
- `rst` asserted mid-STABLE between clock edges → all outputs at their reset values before the next edge; the sequence restarts from PLL_RST.
